// File: rtl/ef_smsdac_dec.sv
// ef_smsdac_dec: rebuilds the code from 3-level element pairs, flags decode mismatches
// and checks that each layer's running usage imbalance stays bounded.
module ef_smsdac_dec #(
   parameter int BITS  = 8,
   parameter int ACC_W = 4,
   parameter int BOUND = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_b,
   input  logic              i_valid,
   input  logic              i_en,
   input  logic [2*BITS-1:0] i_y,
   input  logic [BITS:0]     i_x,
   input  logic              i_clr,
   output logic              o_valid,
   output logic [BITS:0]     o_x,
   output logic              o_err,
   output logic [15:0]       o_err_cnt,
   output logic [BITS-1:0]   o_bound_err
);
   localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(2**(ACC_W-1)-1);
   localparam logic signed [ACC_W:0] SBND = (ACC_W+1)'(BOUND);

   logic                            a_valid_q, a_en_q;
   logic [2*BITS-1:0]               a_y_q;
   logic [BITS:0]                   a_x_q;
   logic [BITS:0]                   x_dec, x_d, x_q;
   logic                            valid_d, valid_q, err_d, err_q;
   logic [15:0]                     cnt_d, cnt_q;
   logic [BITS-1:0][ACC_W-1:0]      s_d, s_q;
   logic [BITS-1:0]                 bound_d, bound_q;

   always_ff @(posedge i_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         a_valid_q <= 1'b0;
         a_en_q    <= 1'b0;
         a_y_q     <= '0;
         a_x_q     <= '0;
         valid_q   <= 1'b0;
         x_q       <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         s_q       <= '0;
         bound_q   <= '0;
      end else begin
         a_valid_q <= i_valid;
         a_en_q    <= i_en;
         a_y_q     <= i_y;
         a_x_q     <= i_x;
         valid_q   <= valid_d;
         x_q       <= x_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         s_q       <= s_d;
         bound_q   <= bound_d;
      end

   // Each layer contributes 0, 1 or 2 units of weight 2^k.
   always_comb begin
      x_dec = '0;
      for (int k = 0; k < BITS; k++)
         x_dec = x_dec + (((BITS+1)'(a_y_q[2*k+1]) + (BITS+1)'(a_y_q[2*k])) << k);
   end

   always_comb begin
      valid_d = a_valid_q;
      x_d     = a_valid_q ? x_dec : x_q;
      err_d   = a_valid_q & (x_dec != a_x_q);
      cnt_d   = i_clr ? '0 : (err_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end

   // Clear wins over update; disabled shaping parks every accumulator at zero.
   always_comb begin
      s_d     = s_q;
      bound_d = bound_q;
      for (int k = 0; k < BITS; k++) begin
         logic signed [ACC_W:0] d, sum, sat;
         d   = $signed((ACC_W+1)'(a_y_q[2*k+1])) - $signed((ACC_W+1)'(a_y_q[2*k]));
         sum = $signed({s_q[k][ACC_W-1], s_q[k]}) + d;
         sat = (sum > SMAX) ? SMAX : (sum < -SMAX) ? -SMAX : sum;
         s_d[k] = i_clr ? '0 : !a_valid_q ? s_q[k] : !a_en_q ? '0 : sat[ACC_W-1:0];
         bound_d[k] = !i_clr & (bound_q[k] | (a_valid_q & a_en_q & ((sat > SBND) || (sat < -SBND))));
      end
   end

   assign o_valid     = valid_q;
   assign o_x         = x_q;
   assign o_err       = err_q;
   assign o_err_cnt   = cnt_q;
   assign o_bound_err = bound_q;
endmodule

// File: tb/tb_ef_smsdac_dec.sv
// tb_ef_smsdac_dec: directed vectors with hand-computed expectations for decode,
// error counting, imbalance bounding and clear priority.
module tb_ef_smsdac_dec;
   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        i_valid = 1'b0, i_en = 1'b0, i_clr = 1'b0;
   logic [15:0] i_y = '0;
   logic [8:0]  i_x = '0;
   logic        o_valid, o_err;
   logic [8:0]  o_x;
   logic [15:0] o_err_cnt;
   logic [7:0]  o_bound_err;
   int          n_chk = 0, n_pass = 0;

   ef_smsdac_dec dut (
      .i_clk(clk), .i_rst_b(rst_b), .i_valid(i_valid), .i_en(i_en), .i_y(i_y),
      .i_x(i_x), .i_clr(i_clr), .o_valid(o_valid), .o_x(o_x), .o_err(o_err),
      .o_err_cnt(o_err_cnt), .o_bound_err(o_bound_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic e, input logic [15:0] y, input logic [8:0] x);
      i_valid = v;
      i_en    = e;
      i_y     = y;
      i_x     = x;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 16'h0, 9'h0);
   endtask

   task automatic clear();
      i_clr = 1'b1;
      idle(1);
      i_clr = 1'b0;
   endtask

   initial begin
      // reset with random inputs
      for (int i = 0; i < 4; i++) beat(1'b1, 1'($urandom), 16'($urandom), 9'($urandom));
      chk("rst_valid", o_valid, 0);
      chk("rst_x", o_x, 0);
      chk("rst_err", o_err, 0);
      chk("rst_cnt", o_err_cnt, 0);
      chk("rst_bound", o_bound_err, 0);
      rst_b = 1'b1;
      idle(3);
      chk("post_rst_valid", o_valid, 0);
      chk("post_rst_x", o_x, 0);
      chk("post_rst_cnt", o_err_cnt, 0);

      // full-scale decode, two-cycle latency
      beat(1'b1, 1'b0, 16'hFFFF, 9'd510);
      beat(1'b1, 1'b0, 16'h0000, 9'd0);
      chk("fs_valid", o_valid, 1);
      chk("fs_x", o_x, 510);
      chk("fs_err", o_err, 0);
      idle(1);
      chk("zero_x", o_x, 0);
      chk("zero_valid", o_valid, 1);
      idle(1);
      chk("idle_valid", o_valid, 0);
      chk("idle_hold_x", o_x, 0);

      // mismatch: layer 2 = 01 decodes to 4
      beat(1'b1, 1'b0, 16'h0010, 9'd5);
      idle(1);
      chk("mm_x", o_x, 4);
      chk("mm_err", o_err, 1);
      chk("mm_cnt", o_err_cnt, 1);
      idle(1);
      chk("mm_pulse", o_err, 0);
      chk("mm_cnt_hold", o_err_cnt, 1);
      for (int i = 0; i < 65600; i++) beat(1'b1, 1'b0, 16'h0010, 9'd5);
      idle(2);
      chk("cnt_sat", o_err_cnt, 16'hFFFF);
      clear();
      chk("cnt_clr", o_err_cnt, 0);

      // imbalance: +1 three times
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      chk("imb_two", o_bound_err, 0);
      idle(1);
      chk("imb_three", o_bound_err, 8'h01);
      chk("imb_no_err", o_err_cnt, 0);
      idle(3);
      chk("imb_sticky", o_bound_err, 8'h01);
      clear();
      chk("imb_clr", o_bound_err, 0);

      // alternating stays within bound
      for (int i = 0; i < 1000; i++)
         beat(1'b1, 1'b1, (i % 2 == 0) ? 16'h0002 : 16'h0001, 9'd1);
      idle(2);
      chk("alt_bound", o_bound_err, 0);
      chk("alt_cnt", o_err_cnt, 0);

      // disabled shaping forces s to 0 and blocks flags
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 16'h0002, 9'd1);
      idle(2);
      chk("dis_bound", o_bound_err, 0);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      idle(2);
      chk("reen_from_zero", o_bound_err, 0);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      idle(2);
      chk("reen_third", o_bound_err, 8'h01);

      // clear priority over error count
      clear();
      beat(1'b1, 1'b0, 16'h0010, 9'd5);
      idle(2);
      chk("pre_clr_cnt", o_err_cnt, 1);
      beat(1'b1, 1'b0, 16'h0010, 9'd5);
      clear();
      chk("clr_err_pulse", o_err, 1);
      chk("clr_cnt_prio", o_err_cnt, 0);

      // clear priority over flag set, then re-violation
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      clear();
      chk("clr_bound_prio", o_bound_err, 0);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      beat(1'b1, 1'b1, 16'h0002, 9'd1);
      idle(1);
      chk("reset_bound", o_bound_err, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
